// File: rtl/cobs_frame_check.sv
`default_nettype none
// ============================================================================
// Module   : cobs_frame_check
// Purpose  : Store-and-forward frame validator placed after a COBS decoder.
//            Each frame is buffered tentatively. Only frames whose trailing
//            check byte verifies are committed to the consumer, with the
//            check byte removed. Frames that fail the check, are too short,
//            overflow the buffer or are hit by a decoder error are discarded.
// Config   : COBS_FRAME_CHECK_CRC8_EN -- when defined, the frame check is
//            CRC-8 (poly 0x07, init 0x00, no reflection, no xorout).
//            Otherwise it is the additive sum mod 256.
// Ports    : clk, rst (async, active-high)
//            i_error, i_data[7:0], i_valid, i_last   decoded input stream
//            o_data[7:0], o_valid, o_ready, o_last   payload output (ready/valid)
//            frame_good / frame_drop                 one-cycle status pulses
//            drop_count[15:0]                        saturating drop counter
// Revision : 1.0  initial release
// ============================================================================
module cobs_frame_check #(
  parameter int DEPTH = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_error,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_last,
  output logic        frame_good,
  output logic        frame_drop,
  output logic [15:0] drop_count
);

  localparam int DW = 8;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Buffer entries are {last, data}
  logic [DW:0]    mem [DEPTH];

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  wr_tmp;
  logic [AW-1:0]  rd_ptr;

  logic           hold_valid;
  logic [DW-1:0]  hold_data;
  logic [7:0]     chk;
  logic [7:0]     len;
  logic           ovf;

  logic [DW:0]    rd_q;
  logic           rd_valid;

  logic           in_fire;
  logic           empty;
  logic           out_load;
  logic           rd_en;
  logic [AW-1:0]  rd_ptr_nxt;
  logic           full;
  logic           do_write;
  logic           ovf_set;
  logic [7:0]     chk_nxt;
  logic [7:0]     len_nxt;
  logic           frame_ok;

`ifdef COBS_FRAME_CHECK_CRC8_EN
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int k = 0; k < 8; k++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction
`endif

  always_comb begin
    in_fire    = i_valid & ~i_error;
    empty      = (rd_ptr == wr_ptr);
    // The output register can take a new word when empty or being drained
    out_load   = ~o_valid | o_ready;
    rd_en      = ~empty & (~rd_valid | out_load);
    rd_ptr_nxt = rd_en ? (rd_ptr + PTR_ONE) : rd_ptr;
    // Compare against the post-edge read pointer so an entry freed on the
    // same edge is usable by the write
    full       = ((wr_tmp + PTR_ONE) == rd_ptr_nxt);
    do_write   = in_fire & hold_valid & ~ovf & ~full;
    ovf_set    = in_fire & hold_valid & ~ovf & full;
`ifdef COBS_FRAME_CHECK_CRC8_EN
    chk_nxt    = crc8_byte(chk, i_data);
`else
    chk_nxt    = chk + i_data;
`endif
    len_nxt    = (len == 8'hFF) ? len : (len + 8'd1);
    frame_ok   = (chk_nxt == 8'h00) & (len_nxt >= 8'd2) & ~(ovf | ovf_set);
  end

  // Buffer storage and registered read port (no reset: plain RAM)
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_tmp] <= {i_last, hold_data};
    end
    if (rd_en) begin
      rd_q <= mem[rd_ptr];
    end
  end

  // Write side: hold register, running check, commit / discard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      wr_tmp     <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      chk        <= 8'h00;
      len        <= 8'h00;
      ovf        <= 1'b0;
      frame_good <= 1'b0;
      frame_drop <= 1'b0;
      drop_count <= 16'h0000;
    end else begin
      frame_good <= 1'b0;
      frame_drop <= 1'b0;
      if (i_error) begin
        wr_tmp     <= wr_ptr;
        hold_valid <= 1'b0;
        hold_data  <= '0;
        chk        <= 8'h00;
        len        <= 8'h00;
        ovf        <= 1'b0;
        if (len != 8'h00) begin
          frame_drop <= 1'b1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
      end else if (i_valid) begin
        if (do_write) wr_tmp <= wr_tmp + PTR_ONE;
        if (ovf_set)  ovf    <= 1'b1;
        if (i_last) begin
          hold_valid <= 1'b0;
          hold_data  <= '0;
          chk        <= 8'h00;
          len        <= 8'h00;
          ovf        <= 1'b0;
          if (frame_ok) begin
            // frame_ok implies the held byte is written on this edge
            wr_ptr     <= wr_tmp + PTR_ONE;
            frame_good <= 1'b1;
          end else begin
            wr_tmp     <= wr_ptr;
            frame_drop <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
          end
        end else begin
          hold_valid <= 1'b1;
          hold_data  <= i_data;
          chk        <= chk_nxt;
          len        <= len_nxt;
        end
      end
    end
  end

  // Read side: memory-read stage feeding the output register (FWFT)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_last   <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (rd_en) begin
        rd_valid <= 1'b1;
      end else if (out_load) begin
        rd_valid <= 1'b0;
      end
      if (out_load) begin
        o_valid <= rd_valid;
        if (rd_valid) begin
          o_last <= rd_q[DW];
          o_data <= rd_q[DW-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cobs_frame_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_cobs_frame_check
// Purpose  : Directed self-checking bench for cobs_frame_check (DEPTH=4).
//            Honours COBS_FRAME_CHECK_CRC8_EN to select the CRC-8 scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_cobs_frame_check;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_error = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        o_ready = 1'b1;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic        frame_good;
  logic        frame_drop;
  logic [15:0] drop_count;

  cobs_frame_check #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_error(i_error), .i_data(i_data),
    .i_valid(i_valid), .i_last(i_last), .o_data(o_data), .o_valid(o_valid),
    .o_ready(o_ready), .o_last(o_last), .frame_good(frame_good),
    .frame_drop(frame_drop), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic toggle = 1'b0;

  // Observed output transfers {last, data} and status pulse counts
  logic [8:0] got[$];
  int good_n = 0;
  int drop_n = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && o_ready) got.push_back({o_last, o_data});
      if (frame_good) good_n++;
      if (frame_drop) drop_n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) o_ready = ~o_ready;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    tick();
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({o_valid, o_last, o_data, frame_good, frame_drop, drop_count} !== 28'h0)
      $display("FAIL reset_outputs: got v=%b l=%b d=%h g=%b dr=%b cnt=%h want all zero",
               o_valid, o_last, o_data, frame_good, frame_drop, drop_count);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || drop_count !== 16'h0)
      $display("FAIL reset_release: got v=%b cnt=%h want v=0 cnt=0000", o_valid, drop_count);
    else passes++;
    tick();
  endtask

  task automatic test_good();
    int base;
    int g0;
    logic [8:0] exp[$];
    logic [8:0] gv;
    base = got.size();
    g0 = good_n;
    exp = '{9'h001, 9'h002, 9'h103};
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'hFA, 1'b1);
    @(negedge clk);
    checks++;
    if (frame_good !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL good_e0: got good=%b v=%b want good=1 v=0", frame_good, o_valid);
    else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (frame_good !== 1'b0 || o_valid !== 1'b0)
      $display("FAIL good_e1: got good=%b v=%b want good=0 v=0", frame_good, o_valid);
    else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h01 || o_last !== 1'b0)
      $display("FAIL good_e2: got v=%b d=%h l=%b want v=1 d=01 l=0", o_valid, o_data, o_last);
    else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h02)
      $display("FAIL good_e3: got v=%b d=%h want v=1 d=02", o_valid, o_data);
    else passes++;
    tick();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h03 || o_last !== 1'b1)
      $display("FAIL good_e4: got v=%b d=%h l=%b want v=1 d=03 l=1", o_valid, o_data, o_last);
    else passes++;
    idle(6);
    checks++;
    if (got.size() - base != exp.size())
      $display("FAIL good_len: got %0d want %0d", got.size() - base, exp.size());
    else passes++;
    for (int i = 0; i < exp.size(); i++) begin
      gv = (base + i < got.size()) ? got[base + i] : 9'hxxx;
      checks++;
      if (gv !== exp[i]) $display("FAIL good_data[%0d]: got %h want %h", i, gv, exp[i]);
      else passes++;
    end
    checks++;
    if (good_n - g0 != 1) $display("FAIL good_count: got %0d want 1", good_n - g0);
    else passes++;
  endtask

  task automatic test_bad();
    int base;
    int d0;
    logic [8:0] gv;
    base = got.size();
    d0 = drop_n;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'hFB, 1'b1);
    idle(5);
    checks++;
    if (got.size() != base || drop_n - d0 != 1 || drop_count !== 16'd1)
      $display("FAIL bad_drop: got out=%0d drops=%0d cnt=%0d want out=0 drops=1 cnt=1",
               got.size() - base, drop_n - d0, drop_count);
    else passes++;
    send(8'h05, 1'b0); send(8'hFB, 1'b1);
    idle(5);
    gv = (got.size() > base) ? got[base] : 9'hxxx;
    checks++;
    if (got.size() - base != 1 || gv !== 9'h105)
      $display("FAIL bad_next: got n=%0d first=%h want n=1 first=105", got.size() - base, gv);
    else passes++;
  endtask

  task automatic test_short();
    int base;
    base = got.size();
    send(8'h00, 1'b1);
    idle(4);
    checks++;
    if (got.size() != base || drop_count !== 16'd2)
      $display("FAIL short_drop: got out=%0d cnt=%0d want out=0 cnt=2", got.size() - base, drop_count);
    else passes++;
  endtask

  task automatic test_overflow();
    int base;
    logic [8:0] gv;
    base = got.size();
    o_ready = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    send(8'h04, 1'b0); send(8'h05, 1'b0); send(8'hF1, 1'b1);
    idle(4);
    checks++;
    if (o_valid !== 1'b0 || drop_count !== 16'd3)
      $display("FAIL ovf_drop: got v=%b cnt=%0d want v=0 cnt=3", o_valid, drop_count);
    else passes++;
    o_ready = 1'b1;
    send(8'h07, 1'b0); send(8'hF9, 1'b1);
    idle(6);
    gv = (got.size() > base) ? got[base] : 9'hxxx;
    checks++;
    if (got.size() - base != 1 || gv !== 9'h107)
      $display("FAIL ovf_next: got n=%0d first=%h want n=1 first=107", got.size() - base, gv);
    else passes++;
  endtask

  task automatic test_error();
    int base;
    int d0;
    logic [8:0] exp[$];
    logic [8:0] gv;
    // Plain abort, then a good frame
    base = got.size();
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    i_error = 1'b1; tick(); i_error = 1'b0;
    send(8'h09, 1'b0); send(8'hF7, 1'b1);
    idle(6);
    gv = (got.size() > base) ? got[base] : 9'hxxx;
    checks++;
    if (drop_count !== 16'd4 || got.size() - base != 1 || gv !== 9'h109)
      $display("FAIL err_abort: got cnt=%0d n=%0d first=%h want cnt=4 n=1 first=109",
               drop_count, got.size() - base, gv);
    else passes++;
    // Same with o_ready toggling, then a multi-byte frame for ordering
    base = got.size();
    toggle = 1'b1;
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    i_error = 1'b1; tick(); i_error = 1'b0;
    send(8'h09, 1'b0); send(8'hF7, 1'b1);
    idle(8);
    send(8'h0A, 1'b0); send(8'h0B, 1'b0); send(8'h0C, 1'b0); send(8'hDF, 1'b1);
    idle(12);
    toggle = 1'b0;
    o_ready = 1'b1;
    idle(2);
    exp = '{9'h109, 9'h00A, 9'h00B, 9'h10C};
    checks++;
    if (got.size() - base != exp.size() || drop_count !== 16'd5)
      $display("FAIL err_toggle_len: got n=%0d cnt=%0d want n=%0d cnt=5",
               got.size() - base, drop_count, exp.size());
    else passes++;
    for (int i = 0; i < exp.size(); i++) begin
      gv = (base + i < got.size()) ? got[base + i] : 9'hxxx;
      checks++;
      if (gv !== exp[i]) $display("FAIL err_toggle_data[%0d]: got %h want %h", i, gv, exp[i]);
      else passes++;
    end
    // i_error together with i_last: one drop only, no output
    base = got.size();
    d0 = drop_n;
    send(8'h01, 1'b0);
    i_error = 1'b1; i_valid = 1'b1; i_last = 1'b1; i_data = 8'hFF;
    tick();
    i_error = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    idle(5);
    checks++;
    if (drop_n - d0 != 1 || drop_count !== 16'd6 || got.size() != base)
      $display("FAIL err_last: got drops=%0d cnt=%0d out=%0d want drops=1 cnt=6 out=0",
               drop_n - d0, drop_count, got.size() - base);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int base;
    int g0;
    logic [8:0] exp[$];
    logic [8:0] gv;
    base = got.size();
    g0 = good_n;
    exp = '{9'h101, 9'h102, 9'h003, 9'h110};
    send(8'h01, 1'b0); send(8'hFF, 1'b1);
    send(8'h02, 1'b0); send(8'hFE, 1'b1);
    send(8'h03, 1'b0); send(8'h10, 1'b0); send(8'hED, 1'b1);
    idle(8);
    checks++;
    if (got.size() - base != exp.size() || good_n - g0 != 3)
      $display("FAIL b2b_len: got n=%0d goods=%0d want n=4 goods=3", got.size() - base, good_n - g0);
    else passes++;
    for (int i = 0; i < exp.size(); i++) begin
      gv = (base + i < got.size()) ? got[base + i] : 9'hxxx;
      checks++;
      if (gv !== exp[i]) $display("FAIL b2b_data[%0d]: got %h want %h", i, gv, exp[i]);
      else passes++;
    end
  endtask

  task automatic test_crc();
    int base;
    logic [8:0] gv;
    base = got.size();
    send(8'h01, 1'b0); send(8'h07, 1'b1);
    idle(6);
    gv = (got.size() > base) ? got[base] : 9'hxxx;
    checks++;
    if (got.size() - base != 1 || gv !== 9'h101)
      $display("FAIL crc_good: got n=%0d first=%h want n=1 first=101", got.size() - base, gv);
    else passes++;
    base = got.size();
    send(8'h01, 1'b0); send(8'h08, 1'b1);
    idle(6);
    checks++;
    if (got.size() != base || drop_count !== 16'd1)
      $display("FAIL crc_bad: got out=%0d cnt=%0d want out=0 cnt=1", got.size() - base, drop_count);
    else passes++;
  endtask

  initial begin
    test_reset();
`ifdef COBS_FRAME_CHECK_CRC8_EN
    test_crc();
`else
    test_good();
    test_bad();
    test_short();
    test_overflow();
    test_error();
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cobs_frame_check.md
# cobs_frame_check

Store-and-forward frame validator directly downstream of the COBS decoder. It buffers each decoded frame, checks the trailing check byte, and releases only good frames to the consumer. Bad, short, overflowed or decoder-errored frames are discarded entirely. The output is a ready/valid byte stream with the check byte stripped.

## Interface
Parameters:
- DEPTH, 512, buffer entries (power of two, ≥4); each entry is {last, data[7:0]}
- DW, 8, byte width (localparam, fixed)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- i_error  in  1  decoder error flag (level)
- i_data  in  8  decoded byte
- i_valid  in  1  byte qualifier; no backpressure, always accepted
- i_last  in  1  final byte of frame (the check byte)
- o_data  out  8  payload byte
- o_valid  out  1  output qualifier
- o_ready  in  1  consumer accept
- o_last  out  1  final payload byte of frame
- frame_good  out  1  one-cycle pulse when a frame commits
- frame_drop  out  1  one-cycle pulse when a frame is discarded
- drop_count  out  16  saturating count of discarded frames

## Operation
- Pointers:
  - wr_ptr is the committed write pointer.
  - wr_tmp is the tentative write pointer.
  - rd_ptr is the read pointer.
  - All pointers are log2(DEPTH) bits and wrap naturally.
  - Empty when rd_ptr == wr_ptr. Full when wr_tmp+1 == rd_ptr.
- One-byte hold register: each accepted byte is held. The previously held byte is written at wr_tmp when the next byte arrives. The check byte is never written.
- i_last with a held byte present: write the held byte with last=1.
- Running check: the additive sum of all frame bytes mod 256, including the check byte. A frame passes when the sum is 0x00. The frame length counter saturates at 255.
- Frame end (i_valid & i_last):
  - good = (check passes) & (length ≥ 2) & (no overflow).
  - Good: wr_ptr <= wr_tmp after the final write, and pulse frame_good.
  - Otherwise: wr_tmp <= wr_ptr, pulse frame_drop, and increment drop_count (saturates at 0xFFFF).
  - The check state, length, hold register and overflow flag are cleared either way.
- Overflow: a write while full sets the overflow flag. Further writes in that frame are suppressed, and the frame is dropped at i_last.
- i_error high:
  - Abort immediately: wr_tmp <= wr_ptr and clear the frame state.
  - If the frame had ≥1 byte, pulse frame_drop and count the drop.
  - Inputs are ignored while i_error is high. The next frame starts on the first i_valid after i_error falls.
- Read side:
  - Output register plus 1-cycle memory read, with first-word-fall-through behaviour.
  - A transfer occurs when o_valid & o_ready.
  - o_data/o_valid/o_last are held stable while o_valid & !o_ready.
- Reads and writes proceed concurrently. Only committed data (behind wr_ptr) is readable.

## Timing
- Reset values: o_data 0, o_valid 0, o_last 0, frame_good 0, frame_drop 0, drop_count 0. All pointers are 0; hold, check and overflow state are cleared. Reset mid-frame discards everything, including committed data.
- Commit latency: the frame commits at edge E0, the edge that samples i_last. o_valid rises after edge E2 when the buffer was empty and o_ready is high.
- frame_good and frame_drop are asserted for the cycle after E0.
- Throughput: one byte per cycle in each direction with o_ready held high. There are no bubbles within or between committed frames.
- Simultaneous events:
  - A read freeing an entry on the same edge as a write counts for the full check (no overflow).
  - i_error and i_last on the same cycle: i_error wins, and exactly one drop is counted.
  - Back-to-back frames: i_last at cycle n and the first byte of the next frame at n+1 is supported.

## Configuration
- COBS_FRAME_CHECK_CRC8_EN defined: the check is CRC-8, polynomial 0x07, init 0x00, no reflection, no xorout. It runs over payload plus check byte, and a frame passes when the remainder is 0x00.
- Not defined: the additive mod-256 sum described above. All other behaviour is identical.

## Test plan
- Frame 01 02 03 FA, o_ready=1 -> outputs 01 02 03 with o_last on 03, one frame_good, o_valid rising 2 edges after i_last.
- Frame 01 02 03 FB -> no output, one frame_drop, drop_count=1, wr_tmp restored; the next good frame 05 FB outputs 05.
- Single-byte frame 00 (length 1) -> dropped; drop_count increments.
- DEPTH=4 with o_ready=0 and a 6-byte good frame -> overflow drop. Then o_ready=1 with a 2-byte frame 07 F9 -> outputs 07 only.
- i_error pulsed mid-frame after 01 02, then frame 09 F7 -> one drop, output 09 with o_last. Repeat with o_ready toggling every cycle; the data order is preserved.
- With COBS_FRAME_CHECK_CRC8_EN: frame 01 07 -> outputs 01; frame 01 08 -> dropped.
